i2s_adc_capture: RTL and testbench
==================================

// Module: i2s_adc_capture
// PURPOSE
//  Receive side of the codec audio link: deserialises WM8731 ADC data (Philips I2S, MSB first,
//  1-bit delay) using the BCLK/LRCLK already generated in the clk domain.
//  Captured 24-bit samples are written into a BRAM ring buffer, with interleaved left and right
//  channels, for later playback or UART readout.
//  Also presents each sample on a valid-pulse stream.
// PARAMETERS
//  SAMPLE_BITS  24     bits per channel word captured (MSB first); extra BCLKs in a half-frame ignored
//  FRAMES       30000  stereo frames in ring; BRAM word slots used = 2*FRAMES
// PORTS
//  clk          in   1   system clock (73.728 MHz); i2s_* inputs are synchronous to it
//  rstn         in   1   asynchronous active-low reset
//  i2s_bclk     in   1   bit clock (clk/32), registered in clk domain
//  i2s_lrclk    in   1   word select: 0 = left, 1 = right
//  i2s_adcdat   in   1   serial ADC data from codec
//  capture_en   in   1   1 = write samples to BRAM; sampled only at left-word start
//  sample_data  out  24  last completed word
//  sample_right out  1   channel of sample_data (1 = right)
//  sample_valid out  1   1-cycle pulse per completed word
//  bram_clkb    out  1   = clk
//  bram_rstb    out  1   constant 0
//  bram_enb     out  1   1 during the write cycle only
//  bram_web     out  4   4'hF during write, else 0
//  bram_addrb   out  32  byte address = slot*4
//  bram_dinb    out  32  {8{sample sign bit}, sample[23:0]}
//  wrapped      out  1   sticky: write pointer has wrapped FRAMES-1 -> 0
//  frame_err    out  1   sticky: truncated word or unpaired right word seen
// BEHAVIOUR
//  Reset: all outputs 0 except bram_clkb; internal state = IDLE, frame ptr 0, recording off.
//  Edge detect: bclk_q <= i2s_bclk each clk; a "rise" is a clk edge with bclk_q=0 and i2s_bclk=1.
//  On a rise, i2s_lrclk and i2s_adcdat are sampled the same clk. ws_q holds lrclk from the previous rise.
//  States: IDLE (no word armed), ARMED (word open, 0..SAMPLE_BITS-1 bits), FULL (SAMPLE_BITS bits, waiting).
//  Rise with lrclk != ws_q (word boundary). Bit order within this one rise:
//   1. ARMED with SAMPLE_BITS-1 bits: this bit is the LSB and the word completes.
//      ARMED with fewer bits: discard the word and set frame_err.
//   2. Arm a new word: channel = lrclk, bit count = 0.
//      Go to ARMED without shifting, which gives the 1-bit I2S delay.
//   3. If lrclk=0, latch rec = capture_en for this frame.
//  Rise without boundary:
//   - ARMED: shift adcdat into the LSB and increment the bit count.
//   - Reaching SAMPLE_BITS completes the word and moves to FULL.
//   - IDLE/FULL: bit ignored.
//  First boundary after reset only arms; no word can complete before it.
//  Completion: registered; the clk after the completing rise, sample_valid=1 and
//   sample_data/sample_right update.
//   If rec=1, the BRAM write happens on the same clk.
//  Slots:
//   - left -> slot 2*fptr; a left write sets left_ok.
//   - right with left_ok=1 -> slot 2*fptr+1; clear left_ok; fptr increments.
//   - fptr = FRAMES-1 wraps to 0 and sets wrapped.
//   - right with left_ok=0 -> no write, frame_err set, fptr unchanged.
//  capture_en dropping mid-frame: the right word of a recorded frame is still written.
//   Recording stops at the next left boundary.
//  rstn asserted mid-word or mid-write: immediate return to reset state; partial word lost.
//   Restart waits for the next boundary.
//  No back-pressure: one write per completed word, and words are at least 32 clk apart.
// TESTING
//  1. Model codec drives L=24'hA5A5A5, R=24'h5A5A5A, capture_en=1, 3 frames.
//     Expect: valid pulses L,R,L,R,L,R; writes to slot 0=32'hFFA5A5A5, slot 1=32'h005A5A5A,
//     then slots 2..5; bram_addrb 0,4,8,..,20.
//  2. FRAMES=4, 5 frames with L=frame#.
//     Expect: slot 8 wraps to 0, holding 24'h000004; wrapped=1 after 4th right write.
//  3. Shorten one left half to 10 BCLKs.
//     Expect: no valid for that word, frame_err=1, following right not written.
//     Next frame resumes at the same fptr.
//  4. Drop capture_en after the left half of frame 2.
//     Expect: frame 2 right written; frame 3 gives valid pulses but bram_enb stays 0.
//  5. Assert rstn low for 3 clk at bit 12 of a right word.
//     Expect: outputs 0 during reset; first valid after reset is the next full left word.
//     That word is written to slot 0.
//  6. SAMPLE_BITS=16 with the 24-BCLK half-frame.
//     Expect: word completes at bit 16; trailing 8 bits ignored; no frame_err.

Source files
------------

// File: rtl/i2s_adc_capture.sv
// I2S (Philips, MSB first, 1-bit delay) ADC receiver that writes interleaved
// stereo samples into a BRAM ring and presents each word on a valid-pulse stream.
//
// Ports:
//   clk, rstn                    system clock, asynchronous active-low reset
//   i2s_bclk, i2s_lrclk          bit clock and word select (0 = left), clk-synchronous
//   i2s_adcdat                   serial ADC data
//   capture_en                   record enable, sampled at each left-word start
//   sample_data, sample_right    last completed word and its channel
//   sample_valid                 1-cycle pulse per completed word
//   bram_*                       BRAM port B write interface (byte address = slot*4)
//   wrapped, frame_err           sticky status flags
module i2s_adc_capture #(
    parameter int SAMPLE_BITS = 24,
    parameter int FRAMES      = 30000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i2s_bclk,
    input  logic        i2s_lrclk,
    input  logic        i2s_adcdat,
    input  logic        capture_en,
    output logic [23:0] sample_data,
    output logic        sample_right,
    output logic        sample_valid,
    output logic        bram_clkb,
    output logic        bram_rstb,
    output logic        bram_enb,
    output logic [3:0]  bram_web,
    output logic [31:0] bram_addrb,
    output logic [31:0] bram_dinb,
    output logic        wrapped,
    output logic        frame_err
);

    localparam int PW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int CW = $clog2(SAMPLE_BITS + 1);

    typedef enum logic [1:0] {IDLE, ARMED, FULL} state_t;

    state_t                   state;
    logic                     bclk_q;
    logic                     ws_q;
    logic                     ws_ok;
    logic                     chan;
    logic                     rec;
    logic                     left_ok;
    logic [CW-1:0]            cnt;
    logic [SAMPLE_BITS-2:0]   shreg;
    logic [PW-1:0]            fptr;

    logic                     rise;
    logic                     boundary;
    logic                     last_bit;
    logic                     complete;
    logic                     trunc;
    logic signed [SAMPLE_BITS-1:0] word;
    logic [31:0]              ext;
    logic [31:0]              slot;

    assign bram_clkb = clk;
    assign bram_rstb = 1'b0;

    assign rise     = !bclk_q && i2s_bclk;
    // ws_q is only meaningful once one rise has been seen since reset,
    // so a restart in the middle of a word never looks like a boundary.
    assign boundary = rise && ws_ok && (i2s_lrclk != ws_q);
    assign last_bit = (cnt == CW'(SAMPLE_BITS - 1));
    // The final bit completes a word whether it arrives on the boundary
    // rise (LSB of a full-length word) or mid half-frame (long frames).
    assign complete = rise && (state == ARMED) && last_bit;
    assign trunc    = boundary && (state == ARMED) && !last_bit;
    assign word     = {shreg, i2s_adcdat};
    assign ext      = 32'(word);
    assign slot     = (32'(fptr) << 1) | 32'(chan);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            bclk_q       <= 1'b0;
            ws_q         <= 1'b0;
            ws_ok        <= 1'b0;
            chan         <= 1'b0;
            rec          <= 1'b0;
            left_ok      <= 1'b0;
            cnt          <= '0;
            shreg        <= '0;
            fptr         <= '0;
            sample_data  <= '0;
            sample_right <= 1'b0;
            sample_valid <= 1'b0;
            bram_enb     <= 1'b0;
            bram_web     <= 4'h0;
            bram_addrb   <= '0;
            bram_dinb    <= '0;
            wrapped      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            bclk_q       <= i2s_bclk;
            sample_valid <= 1'b0;
            bram_enb     <= 1'b0;
            bram_web     <= 4'h0;

            if (rise) begin
                ws_q  <= i2s_lrclk;
                ws_ok <= 1'b1;
            end

            if (complete) begin
                sample_valid <= 1'b1;
                sample_data  <= ext[23:0];
                sample_right <= chan;
                if (rec) begin
                    if (!chan) begin
                        bram_enb   <= 1'b1;
                        bram_web   <= 4'hF;
                        bram_addrb <= slot << 2;
                        bram_dinb  <= ext;
                        left_ok    <= 1'b1;
                    end else if (left_ok) begin
                        bram_enb   <= 1'b1;
                        bram_web   <= 4'hF;
                        bram_addrb <= slot << 2;
                        bram_dinb  <= ext;
                        left_ok    <= 1'b0;
                        if (fptr == PW'(FRAMES - 1)) begin
                            fptr    <= '0;
                            wrapped <= 1'b1;
                        end else begin
                            fptr <= fptr + PW'(1);
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end

            if (trunc) begin
                frame_err <= 1'b1;
            end

            // Arming on the boundary without shifting gives the I2S 1-bit delay.
            // rec uses the old value above, so a frame finishes as it started.
            if (boundary) begin
                state <= ARMED;
                chan  <= i2s_lrclk;
                cnt   <= '0;
                if (!i2s_lrclk) begin
                    rec <= capture_en;
                end
            end else if (rise && state == ARMED) begin
                shreg <= word[SAMPLE_BITS-2:0];
                cnt   <= cnt + CW'(1);
                if (last_bit) begin
                    state <= FULL;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_adc_capture.sv
// Directed bench for i2s_adc_capture: a codec model drives 24-BCLK half-frames
// into a 24-bit/4-frame instance and a 16-bit instance sharing the same link.
module tb_i2s_adc_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, bclk, lrclk, adcdat, cap;

    logic [23:0] a_data, b_data;
    logic        a_right, a_valid, a_clkb, a_rstb, a_enb, a_wrapped, a_err;
    logic        b_right, b_valid, b_clkb, b_rstb, b_enb, b_wrapped, b_err;
    logic [3:0]  a_web, b_web;
    logic [31:0] a_addr, a_din, b_addr, b_din;

    i2s_adc_capture #(.SAMPLE_BITS(24), .FRAMES(4)) dut (
        .clk(clk), .rstn(rstn), .i2s_bclk(bclk), .i2s_lrclk(lrclk),
        .i2s_adcdat(adcdat), .capture_en(cap),
        .sample_data(a_data), .sample_right(a_right), .sample_valid(a_valid),
        .bram_clkb(a_clkb), .bram_rstb(a_rstb), .bram_enb(a_enb),
        .bram_web(a_web), .bram_addrb(a_addr), .bram_dinb(a_din),
        .wrapped(a_wrapped), .frame_err(a_err)
    );

    i2s_adc_capture #(.SAMPLE_BITS(16), .FRAMES(4)) dut16 (
        .clk(clk), .rstn(rstn), .i2s_bclk(bclk), .i2s_lrclk(lrclk),
        .i2s_adcdat(adcdat), .capture_en(cap),
        .sample_data(b_data), .sample_right(b_right), .sample_valid(b_valid),
        .bram_clkb(b_clkb), .bram_rstb(b_rstb), .bram_enb(b_enb),
        .bram_web(b_web), .bram_addrb(b_addr), .bram_dinb(b_din),
        .wrapped(b_wrapped), .frame_err(b_err)
    );

    int checks = 0;
    int errors = 0;
    int web_bad = 0;
    logic prev_lsb;

    logic [24:0] vq[$];
    logic [63:0] wq[$];
    logic [24:0] v16q[$];
    logic [63:0] w16q[$];

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (a_valid) vq.push_back({a_right, a_data});
            if (a_enb) wq.push_back({a_addr, a_din});
            if (b_valid) v16q.push_back({b_right, b_data});
            if (b_enb) w16q.push_back({b_addr, b_din});
            if (a_web !== (a_enb ? 4'hF : 4'h0)) web_bad++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bitx(input logic ws, input logic d);
        @(posedge clk);
        #1;
        lrclk = ws;
        adcdat = d;
        bclk = 1'b0;
        repeat (4) @(posedge clk);
        #1 bclk = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(a_valid), 64'd0);
        chk("mid_rst_data", 64'(a_data), 64'd0);
        chk("mid_rst_right", 64'(a_right), 64'd0);
        chk("mid_rst_enb", 64'(a_enb), 64'd0);
        chk("mid_rst_addr", 64'(a_addr), 64'd0);
        chk("mid_rst_din", 64'(a_din), 64'd0);
        chk("mid_rst_err", 64'(a_err), 64'd0);
        chk("mid_rst_wrapped", 64'(a_wrapped), 64'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // First rise of a half carries the previous word's LSB (1-bit delay).
    task automatic half(input logic ws, input logic [23:0] w, input int n,
                        input int rst_at);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) pulse_reset();
            if (i == 0) bitx(ws, prev_lsb);
            else if (i <= 24) bitx(ws, w[24-i]);
            else bitx(ws, 1'b0);
        end
        prev_lsb = w[0];
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r);
        half(1'b0, l, 24, -1);
        half(1'b1, r, 24, -1);
    endtask

    logic [24:0] exp_v[20];
    logic [63:0] exp_w[16];

    initial begin
        exp_v = '{
            {1'b0, 24'hA5A5A5}, {1'b1, 24'h5A5A5A},
            {1'b0, 24'hA5A5A5}, {1'b1, 24'h5A5A5A},
            {1'b0, 24'hA5A5A5}, {1'b1, 24'h5A5A5A},
            {1'b0, 24'h000003}, {1'b1, 24'h800003},
            {1'b0, 24'h000004}, {1'b1, 24'h800004},
            {1'b1, 24'h222222},
            {1'b0, 24'h333333}, {1'b1, 24'h444444},
            {1'b0, 24'h555555}, {1'b1, 24'h666666},
            {1'b0, 24'h777777}, {1'b1, 24'h888888},
            {1'b0, 24'h999999},
            {1'b0, 24'hBBBBBB}, {1'b1, 24'hCCCCCC}
        };
        exp_w = '{
            {32'd0,  32'hFFA5A5A5}, {32'd4,  32'h005A5A5A},
            {32'd8,  32'hFFA5A5A5}, {32'd12, 32'h005A5A5A},
            {32'd16, 32'hFFA5A5A5}, {32'd20, 32'h005A5A5A},
            {32'd24, 32'h00000003}, {32'd28, 32'hFF800003},
            {32'd0,  32'h00000004}, {32'd4,  32'hFF800004},
            {32'd8,  32'h00333333}, {32'd12, 32'h00444444},
            {32'd16, 32'h00555555}, {32'd20, 32'h00666666},
            {32'd0,  32'hFFBBBBBB}, {32'd4,  32'hFFCCCCCC}
        };

        rstn = 1'b0;
        bclk = 1'b0;
        lrclk = 1'b1;
        adcdat = 1'b0;
        cap = 1'b1;
        prev_lsb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_data", 64'(a_data), 64'd0);
        chk("rst_enb_web", 64'({a_enb, a_web}), 64'd0);
        chk("rst_addr_din", {a_addr, a_din}, 64'd0);
        chk("rst_flags", 64'({a_wrapped, a_err, a_right}), 64'd0);
        chk("rst_bram_rstb", 64'(a_rstb), 64'd0);
        chk("bram_clkb_lo", 64'(a_clkb), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        #2 chk("bram_clkb_hi", 64'(a_clkb), 64'd1);

        // Sync half, then recorded frames including the ring wrap.
        half(1'b1, 24'h000000, 24, -1);
        frame(24'hA5A5A5, 24'h5A5A5A);
        frame(24'hA5A5A5, 24'h5A5A5A);
        frame(24'hA5A5A5, 24'h5A5A5A);
        frame(24'h000003, 24'h800003);
        chk("wrapped_before", 64'(a_wrapped), 64'd0);
        frame(24'h000004, 24'h800004);
        chk("wrapped_after", 64'(a_wrapped), 64'd1);
        chk("err_clean", 64'(a_err), 64'd0);
        chk("err16_clean", 64'(b_err), 64'd0);
        chk("v16_left", 64'(v16q[0]), 64'({1'b0, 24'hFFA5A5}));
        chk("v16_right", 64'(v16q[1]), 64'({1'b1, 24'h005A5A}));
        chk("w16_first", w16q[0], {32'd0, 32'hFFFFA5A5});

        // Truncated left half.
        half(1'b0, 24'h111111, 10, -1);
        half(1'b1, 24'h222222, 24, -1);
        chk("trunc_err", 64'(a_err), 64'd1);
        frame(24'h333333, 24'h444444);

        // capture_en drops after the left half of a recorded frame.
        half(1'b0, 24'h555555, 24, -1);
        cap = 1'b0;
        half(1'b1, 24'h666666, 24, -1);
        frame(24'h777777, 24'h888888);

        // Reset at bit 12 of a right word.
        half(1'b0, 24'h999999, 24, -1);
        cap = 1'b1;
        half(1'b1, 24'hAAAAAA, 24, 12);
        frame(24'hBBBBBB, 24'hCCCCCC);
        half(1'b0, 24'h000000, 24, -1);
        chk("post_rst_err", 64'(a_err), 64'd0);
        chk("post_rst_wrapped", 64'(a_wrapped), 64'd0);

        chk("valid_count", 64'(vq.size()), 64'd20);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("valid_%0d", i), 64'(vq[i]), 64'(exp_v[i]));
        end
        chk("write_count", 64'(wq.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("write_%0d", i), wq[i], exp_w[i]);
        end
        chk("web_pattern", 64'(web_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
